eth_arp_responder: RTL
======================

# eth_arp_responder

Answers ARP requests for the board's own IPv4 address on the 10G Ethernet port, in the `clk156` domain. It watches the MAC's RX AXI-stream, which has no backpressure. It drives the MAC's TX AXI-stream (`tready` handshake) with a 60-byte ARP reply. It sits beside/in front of `eth_encap`, sharing the MAC's RX stream and owning (or arbitrating for) the TX stream.

## Interface
- `MAC_ADDR`, 48'h000A3502AF9A: own MAC address. Network order: bits [47:40] are the first byte on the wire.
- `IP_ADDR`, 32'hC0A80001: own IPv4 address (192.168.0.1).
- `clk156`  in  1: 156.25 MHz core clock; the only clock.
- `eth_rst`  in  1: reset, synchronous and active-high.
- `s_axis_rx_tvalid`  in  1: RX beat valid. There is no `tready`; the block always accepts.
- `s_axis_rx_tdata`  in  64: RX data. Frame byte n is at bits [8*(n%8)+7 : 8*(n%8)].
- `s_axis_rx_tkeep`  in  8: RX byte enables.
- `s_axis_rx_tlast`  in  1: RX end of frame.
- `s_axis_rx_tuser`  in  1: qualified by `tlast`. 1 = good frame, 0 = bad FCS or error.
- `m_axis_tx_tvalid`  out  1: TX beat valid.
- `m_axis_tx_tready`  in  1: MAC ready.
- `m_axis_tx_tdata`  out  64: TX data, same byte order as RX.
- `m_axis_tx_tkeep`  out  8: TX byte enables.
- `m_axis_tx_tlast`  out  1: TX end of frame.
- `m_axis_tx_tuser`  out  1: tied to 0.
- `reply_cnt`  out  16: replies fully sent. Wraps 0xFFFF→0.
- `drop_cnt`  out  16: valid requests dropped because the pending slot was full. Wraps.

## Operation
- **RX parser.** A 3-bit beat index, saturating at 6, is incremented on each `s_axis_rx_tvalid`. It clears to 0 on the beat after `tlast`.
- Fields captured per beat index:
  - Beat 0: bytes 0-5 are the destination MAC.
  - Beat 1: bytes 12-13 are the ethertype; bytes 14-15 are htype.
  - Beat 2: ptype, hlen, plen and oper; bytes 22-23 are SHA[0:1].
  - Beat 3: bytes 24-27 are SHA[2:5]; bytes 28-31 are SPA.
  - Beat 4: bytes 38-39 are TPA[0:1].
  - Beat 5: bytes 40-41 are TPA[2:3].
- **Frame validity.** A frame is a valid request only if all of the following hold:
  - `tlast` arrives at beat index ≥ 5, with `tuser`=1.
  - The destination MAC is FF:FF:FF:FF:FF:FF or `MAC_ADDR`.
  - ethertype = 0x0806, htype = 0x0001, ptype = 0x0800, hlen = 6, plen = 4, oper = 0x0001.
  - TPA = `IP_ADDR`.
  - Anything else is silently ignored, and counters are unchanged.
- **Pending slot** (one entry: SHA and SPA).
  - On a valid request, if the slot is free, or is being freed in the same cycle, load it and set `pending`.
  - Otherwise, increment `drop_cnt`.
- **TX FSM.**
  - **TX_IDLE:** if `pending`, copy the slot into the TX registers, clear `pending`, go to TX_SEND with beat 0.
  - **TX_SEND:** present beat b (0..7). On `tvalid && tready`:
    - if b = 7, increment `reply_cnt` and go to TX_IDLE;
    - otherwise b = b+1.
- **Reply contents** (byte offsets):
  - 0-5: request SHA.
  - 6-11: `MAC_ADDR`.
  - 12-13: 08 06.
  - 14-15: 00 01.
  - 16-17: 08 00.
  - 18: 06. 19: 04.
  - 20-21: 00 02.
  - 22-27: `MAC_ADDR`.
  - 28-31: `IP_ADDR`.
  - 32-37: request SHA.
  - 38-41: request SPA.
  - 42-59: zero padding.
  - Beats 0-6 use `tkeep` = 0xFF. Beat 7 uses `tkeep` = 0x0F with `tlast` = 1.

## Timing
- **Reset values.** All of these are 0: `m_axis_tx_tvalid`, `tdata`, `tkeep`, `tlast`, `tuser`, `reply_cnt`, `drop_cnt`, `pending`, beat indices. FSM = TX_IDLE.
- **Latency.** For an RX `tlast` beat in cycle T:
  - `pending` is set at the edge ending T.
  - `tvalid` is high with beat 0 in cycle T+2, provided TX_IDLE.
- **Handshake.** Once `tvalid` is asserted, `tdata`, `tkeep` and `tlast` stay stable until `tready`. `tvalid` never drops mid-frame.
- **Gap.** After the beat-7 handshake, `tvalid` = 0 for at least 1 cycle before the next frame.
- **Simultaneous events.** A new valid request in the same cycle that TX_IDLE consumes `pending` is accepted, with no drop.
- **Reset mid-operation.**
  - Reset aborts any frame in progress; no `tlast` is emitted.
  - The MAC shares `eth_rst`, so no partial RX frame follows reset.
- **Output style.** All outputs are registered; there is no combinational path from RX to TX.

## Structure
- Package `eth_pkg` holds:
  - `ETHERTYPE_ARP` (16'h0806), `ETHERTYPE_IPV4` (16'h0800).
  - `ARP_HTYPE_ETH`, `ARP_OPER_REQ`, `ARP_OPER_REPLY`.
  - `ARP_FRAME_BEATS` (8), `ARP_LAST_TKEEP` (8'h0F).
  - A byte-lane extract function `get_byte(tdata, n)`.
- One sub-module, `arp_rx_parse`: the beat index, field capture and validity check. It outputs `req_valid` (1-cycle pulse), `req_sha` and `req_spa`.
- The top level holds the pending slot, the TX FSM and the counters.

## Test plan
- **Valid request.** Broadcast ARP request: SHA 00:11:22:33:44:55, SPA 192.168.0.2, TPA 192.168.0.1, `tuser`=1.
  - Expect an 8-beat reply.
  - Beat 0 `tdata` = 64'h0A00_5544_3322_1100.
  - Beat 7 `tkeep` = 0x0F with `tlast`.
  - Beat 5 bytes 40-41 = 00 02 (SPA tail).
  - `reply_cnt` = 1.
- **Wrong target.** Same request with TPA 192.168.0.9 → no `tvalid` within 50 cycles; counters remain 0.
- **Bad frame.** Same request with `tuser`=0 at `tlast` → no reply.
- **Backpressure.** Valid request; `tready` = 0 for 5 cycles at beat 3 → beat 3 held bit-exact; all 8 beats delivered in order.
- **Slot overflow.** Three valid requests back-to-back with `tready` held at 0:
  - Expect the first to be in flight, the second pending, the third dropped; `drop_cnt` = 1.
  - Release `tready` → two replies, with the SHA of requests 1 then 2; `reply_cnt` = 2.
- **Mid-reply reset.** Assert `eth_rst` during beat 4 of a reply → `tvalid` = 0 on the next cycle and both counters = 0. A fresh request afterwards is answered normally.

Source files
------------

// File: rtl/eth_pkg.sv
// Shared Ethernet/ARP constants, request record and byte-lane helper for the
// 64-bit AXI-stream datapath.
package eth_pkg;

    localparam logic [15:0] ETHERTYPE_ARP   = 16'h0806;
    localparam logic [15:0] ETHERTYPE_IPV4  = 16'h0800;
    localparam logic [15:0] ARP_HTYPE_ETH   = 16'h0001;
    localparam logic [15:0] ARP_OPER_REQ    = 16'h0001;
    localparam logic [15:0] ARP_OPER_REPLY  = 16'h0002;
    localparam logic [7:0]  ARP_HLEN_ETH    = 8'd6;
    localparam logic [7:0]  ARP_PLEN_IPV4   = 8'd4;
    localparam int          ARP_FRAME_BEATS = 8;
    localparam logic [7:0]  ARP_LAST_TKEEP  = 8'h0F;

    typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;

    typedef struct packed {
        logic [47:0] sha;
        logic [31:0] spa;
    } arp_req_t;

    // Frame byte n sits in lane n%8, lane 0 being the low byte of tdata.
    function automatic logic [7:0] get_byte(input logic [63:0] tdata, input logic [2:0] n);
        return tdata[8*n +: 8];
    endfunction

endpackage

// File: rtl/arp_rx_parse.sv
// Watches the MAC RX stream, captures the ARP request fields by beat position
// and flags a request aimed at our IPv4 address on the frame's last beat.
module arp_rx_parse
    import eth_pkg::*;
#(
    parameter logic [47:0] MAC_ADDR = 48'h000A3502AF9A,
    parameter logic [31:0] IP_ADDR  = 32'hC0A80001
) (
    input  logic        clk156,
    input  logic        eth_rst,
    input  logic        rx_tvalid,
    input  logic [63:0] rx_tdata,
    input  logic        rx_tlast,
    input  logic        rx_tuser,
    output logic        req_valid,
    output arp_req_t    req
);

    logic [2:0]       idx;
    logic [7:0][7:0]  lane;
    logic [47:0]      dst_mac, sha;
    logic [31:0]      spa;
    logic [15:0]      etype, htype, ptype, oper, tpa_hi, tpa_lo, tpa_lo_now;
    logic [7:0]       hlen, plen;
    logic             hdr_ok;

    always_comb begin
        for (int i = 0; i < 8; i++) lane[i] = get_byte(rx_tdata, i[2:0]);
    end

    // Beat index saturates at 6: everything of interest lives in beats 0..5.
    always_ff @(posedge clk156) begin
        if (eth_rst) begin
            idx <= '0;
        end else if (rx_tvalid) begin
            if (rx_tlast)          idx <= '0;
            else if (idx != 3'd6)  idx <= idx + 3'd1;
        end
    end

    always_ff @(posedge clk156) begin
        if (rx_tvalid) begin
            unique case (idx)
                3'd0: dst_mac <= {lane[0], lane[1], lane[2], lane[3], lane[4], lane[5]};
                3'd1: begin
                    etype <= {lane[4], lane[5]};
                    htype <= {lane[6], lane[7]};
                end
                3'd2: begin
                    ptype       <= {lane[0], lane[1]};
                    hlen        <= lane[2];
                    plen        <= lane[3];
                    oper        <= {lane[4], lane[5]};
                    sha[47:32]  <= {lane[6], lane[7]};
                end
                3'd3: begin
                    sha[31:0] <= {lane[0], lane[1], lane[2], lane[3]};
                    spa       <= {lane[4], lane[5], lane[6], lane[7]};
                end
                3'd4: tpa_hi <= {lane[6], lane[7]};
                3'd5: tpa_lo <= {lane[0], lane[1]};
                default: ;
            endcase
        end
    end

    // A 6-beat frame ends on the beat carrying the TPA tail, so look at it live.
    assign tpa_lo_now = (idx == 3'd5) ? {lane[0], lane[1]} : tpa_lo;

    assign hdr_ok = (dst_mac == 48'hFFFF_FFFF_FFFF || dst_mac == MAC_ADDR) &&
                    etype == ETHERTYPE_ARP  && htype == ARP_HTYPE_ETH &&
                    ptype == ETHERTYPE_IPV4 && hlen  == ARP_HLEN_ETH  &&
                    plen  == ARP_PLEN_IPV4  && oper  == ARP_OPER_REQ;

    assign req_valid = rx_tvalid && rx_tlast && rx_tuser && (idx >= 3'd5) &&
                       hdr_ok && ({tpa_hi, tpa_lo_now} == IP_ADDR);

    assign req.sha = sha;
    assign req.spa = spa;

endmodule

// File: rtl/eth_arp_responder.sv
// ARP responder: one-deep pending slot between the RX parser and a TX FSM that
// streams a 60-byte reply to the MAC over AXI-stream.
module eth_arp_responder
    import eth_pkg::*;
#(
    parameter logic [47:0] MAC_ADDR = 48'h000A3502AF9A,
    parameter logic [31:0] IP_ADDR  = 32'hC0A80001
) (
    input  logic        clk156,
    input  logic        eth_rst,
    input  logic        s_axis_rx_tvalid,
    input  logic [63:0] s_axis_rx_tdata,
    input  logic [7:0]  s_axis_rx_tkeep,
    input  logic        s_axis_rx_tlast,
    input  logic        s_axis_rx_tuser,
    output logic        m_axis_tx_tvalid,
    input  logic        m_axis_tx_tready,
    output logic [63:0] m_axis_tx_tdata,
    output logic [7:0]  m_axis_tx_tkeep,
    output logic        m_axis_tx_tlast,
    output logic        m_axis_tx_tuser,
    output logic [15:0] reply_cnt,
    output logic [15:0] drop_cnt
);

    localparam logic [2:0] LAST_BEAT = 3'(ARP_FRAME_BEATS - 1);

    logic             req_valid;
    arp_req_t         rx_req, slot, tx_req, src;
    logic             pending;
    tx_state_t        state, state_nxt;
    logic [2:0]       beat, beat_nxt;
    logic             consume, load, tx_done, tvalid_nxt, tlast_nxt;
    logic [63:0]      tdata_nxt;
    logic [7:0]       tkeep_nxt;
    logic [0:63][7:0] frame;
    logic             rx_tkeep_unused;

    // Field position within the beat defines the request; byte enables carry nothing extra.
    assign rx_tkeep_unused = ^s_axis_rx_tkeep;
    assign m_axis_tx_tuser = 1'b0;

    arp_rx_parse #(
        .MAC_ADDR (MAC_ADDR),
        .IP_ADDR  (IP_ADDR)
    ) u_rx_parse (
        .clk156    (clk156),
        .eth_rst   (eth_rst),
        .rx_tvalid (s_axis_rx_tvalid),
        .rx_tdata  (s_axis_rx_tdata),
        .rx_tlast  (s_axis_rx_tlast),
        .rx_tuser  (s_axis_rx_tuser),
        .req_valid (req_valid),
        .req       (rx_req)
    );

    // Whole reply in wire order; frame[0] is the first byte out.
    assign src   = (state == TX_IDLE) ? slot : tx_req;
    assign frame = {src.sha, MAC_ADDR, ETHERTYPE_ARP, ARP_HTYPE_ETH, ETHERTYPE_IPV4,
                    ARP_HLEN_ETH, ARP_PLEN_IPV4, ARP_OPER_REPLY, MAC_ADDR, IP_ADDR,
                    src.sha, src.spa, 176'd0};

    always_comb begin
        state_nxt  = state;
        beat_nxt   = beat;
        consume    = 1'b0;
        load       = 1'b0;
        tx_done    = 1'b0;
        tvalid_nxt = m_axis_tx_tvalid;
        unique case (state)
            TX_IDLE: if (pending) begin
                consume    = 1'b1;
                load       = 1'b1;
                beat_nxt   = '0;
                tvalid_nxt = 1'b1;
                state_nxt  = TX_SEND;
            end
            TX_SEND: if (m_axis_tx_tvalid && m_axis_tx_tready) begin
                if (beat == LAST_BEAT) begin
                    tx_done    = 1'b1;
                    tvalid_nxt = 1'b0;
                    state_nxt  = TX_IDLE;
                end else begin
                    load     = 1'b1;
                    beat_nxt = beat + 3'd1;
                end
            end
            default: state_nxt = TX_IDLE;
        endcase
    end

    // Output registers only move on a load or at frame end, so a stalled beat holds.
    always_comb begin
        tdata_nxt = m_axis_tx_tdata;
        tkeep_nxt = m_axis_tx_tkeep;
        tlast_nxt = m_axis_tx_tlast;
        if (load) begin
            for (int i = 0; i < 8; i++) tdata_nxt[8*i +: 8] = frame[{beat_nxt, i[2:0]}];
            tkeep_nxt = (beat_nxt == LAST_BEAT) ? ARP_LAST_TKEEP : 8'hFF;
            tlast_nxt = (beat_nxt == LAST_BEAT);
        end else if (tx_done) begin
            tdata_nxt = '0;
            tkeep_nxt = '0;
            tlast_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk156) begin
        if (eth_rst) begin
            state            <= TX_IDLE;
            beat             <= '0;
            pending          <= 1'b0;
            slot             <= '0;
            tx_req           <= '0;
            m_axis_tx_tvalid <= 1'b0;
            m_axis_tx_tdata  <= '0;
            m_axis_tx_tkeep  <= '0;
            m_axis_tx_tlast  <= 1'b0;
            reply_cnt        <= '0;
            drop_cnt         <= '0;
        end else begin
            state            <= state_nxt;
            beat             <= beat_nxt;
            m_axis_tx_tvalid <= tvalid_nxt;
            m_axis_tx_tdata  <= tdata_nxt;
            m_axis_tx_tkeep  <= tkeep_nxt;
            m_axis_tx_tlast  <= tlast_nxt;
            if (consume) tx_req <= slot;
            if (tx_done) reply_cnt <= reply_cnt + 16'd1;
            // A request landing as the slot drains refills it instead of dropping.
            if (req_valid) begin
                if (!pending || consume) begin
                    slot    <= rx_req;
                    pending <= 1'b1;
                end else begin
                    drop_cnt <= drop_cnt + 16'd1;
                end
            end else if (consume) begin
                pending <= 1'b0;
            end
        end
    end

endmodule
